// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice (alu_arbiter, alu_rr_arbiter).
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } alu_flags_t;

  localparam int CMD_MUL_INC = 9;
  localparam int CMD_MUL_SHL = 10;

endpackage

// File: rtl/alu_rr_arbiter.sv
// One-hot grant over NUM_REQ requesters. ALU_ARB_RR_EN selects round-robin
// (rotating pointer); otherwise fixed priority, lowest index first.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       adv_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef ALU_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int               j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_i[IDX_W'(j)]) begin
        found            = 1'b1;
        gnt_idx_o        = IDX_W'(j);
        gnt_o[IDX_W'(j)] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= '0;
    else if (adv_i)
      ptr_q <= (int'(gnt_idx_o) == NUM_REQ-1) ? '0 : gnt_idx_o + IDX_W'(1);
  end
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, adv_i};

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (req_i[IDX_W'(k)]) gnt_idx_o = IDX_W'(k);
    if (|req_i) gnt_o[gnt_idx_o] = 1'b1;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: grant, issue with clock-enable for the
// command latency, capture result, return it on a valid/ready channel. Macro: ALU_ARB_RR_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CMD_W   = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_opa,
  input  logic [NUM_REQ*WIDTH-1:0]   req_opb,
  input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
  input  logic [NUM_REQ-1:0]         req_mode,
  input  logic [NUM_REQ-1:0]         req_cin,
  input  logic [NUM_REQ*2-1:0]       req_inp_valid,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]         rsp_res,
  output logic [5:0]                 rsp_flags,
  output logic [WIDTH-1:0]           alu_opa,
  output logic [WIDTH-1:0]           alu_opb,
  output logic [CMD_W-1:0]           alu_cmd,
  output logic                       alu_mode,
  output logic                       alu_cin,
  output logic                       alu_ce,
  output logic [1:0]                 alu_inp_valid,
  input  logic [2*WIDTH-1:0]         alu_res,
  input  logic                       alu_err,
  input  logic                       alu_oflow,
  input  logic                       alu_cout,
  input  logic                       alu_g,
  input  logic                       alu_l,
  input  logic                       alu_e
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  arb_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q, lat_d;
  logic [WIDTH-1:0]     opa_q, opb_q;
  logic [CMD_W-1:0]     cmd_q;
  logic                 mode_q, cin_q, ce_q, rsp_valid_q;
  logic [1:0]           iv_q;
  logic [IDX_W-1:0]     id_q;
  logic [2*WIDTH-1:0]   res_q;
  alu_flags_t           flags_q;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 accept;
  logic [WIDTH-1:0]     sel_opa, sel_opb;
  logic [CMD_W-1:0]     sel_cmd;
  logic                 sel_mode, sel_cin;
  logic [1:0]           sel_iv;

  assign accept = (state_q == IDLE) && (|req_valid) && !rst;

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .adv_i     (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = accept ? gnt : '0;

  // One-hot payload mux from the grant vector.
  always_comb begin
    sel_opa  = '0;
    sel_opb  = '0;
    sel_cmd  = '0;
    sel_mode = 1'b0;
    sel_cin  = 1'b0;
    sel_iv   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_opa  = req_opa[k*WIDTH +: WIDTH];
        sel_opb  = req_opb[k*WIDTH +: WIDTH];
        sel_cmd  = req_cmd[k*CMD_W +: CMD_W];
        sel_mode = req_mode[k];
        sel_cin  = req_cin[k];
        sel_iv   = req_inp_valid[k*2 +: 2];
      end
    end
  end

  assign lat_d = (sel_mode && (sel_cmd == CMD_W'(CMD_MUL_INC) || sel_cmd == CMD_W'(CMD_MUL_SHL)))
               ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      iv_q        <= '0;
      ce_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      id_q        <= '0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          opa_q   <= sel_opa;
          opb_q   <= sel_opb;
          cmd_q   <= sel_cmd;
          mode_q  <= sel_mode;
          cin_q   <= sel_cin;
          iv_q    <= sel_iv;
          id_q    <= gnt_idx;
          cnt_q   <= lat_d;
          ce_q    <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: state_q <= WAIT;
        // Counter at 1 means the ALU result is valid in this cycle.
        WAIT: if (cnt_q == CNT_W'(1)) begin
          res_q       <= alu_res;
          flags_q     <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
          ce_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = id_q;
  assign rsp_res       = res_q;
  assign rsp_flags     = flags_q;
  assign alu_opa       = opa_q;
  assign alu_opb       = opb_q;
  assign alu_cmd       = cmd_q;
  assign alu_mode      = mode_q;
  assign alu_cin       = cin_q;
  assign alu_inp_valid = iv_q;
  assign alu_ce        = ce_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single `alu` instance between `NUM_REQ` independent requesters. Arbitrates among pending requests and latches the winner's operands. It then drives the ALU input ports with clock-enable for the command's fixed latency, captures the result and flags, and returns them to the winning requester over a valid/ready response channel. It sits between the requester-side agents and the ALU's `alu_intf` signals, one level above the ALU in the hierarchy.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand width; must match the ALU.
- `CMD_W`, 4: command width.
- `ALU_LAT`, 1: ALU result latency in cycles, counted from the issue cycle, for non-multiply commands.
- `MUL_LAT`, 2: latency for multiply commands (`mode`=1, `cmd`=9 or 10).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: one-hot grant and accept.
- `req_opa`, `req_opb` in NUM_REQ*WIDTH: operands, requester i occupies slice [i*WIDTH +: WIDTH].
- `req_cmd` in NUM_REQ*CMD_W; `req_mode`, `req_cin` in NUM_REQ; `req_inp_valid` in NUM_REQ*2.
- `rsp_valid` out 1; `rsp_ready` in 1; `rsp_id` out $clog2(NUM_REQ): requester index of the response.
- `rsp_res` out 2*WIDTH; `rsp_flags` out 6: {err, oflow, cout, g, l, e}.
- `alu_opa`, `alu_opb` out WIDTH; `alu_cmd` out CMD_W; `alu_mode`, `alu_cin`, `alu_ce` out 1; `alu_inp_valid` out 2.
- `alu_res` in 2*WIDTH; `alu_err`, `alu_oflow`, `alu_cout`, `alu_g`, `alu_l`, `alu_e` in 1.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` is set, the arbiter selects grant g and asserts `req_ready[g]` combinationally in the same cycle.
  - At the clock edge, g's payload is latched into operand registers, `rsp_id`<=g, and the state moves to ISSUE.
  - Latency counter is loaded with MUL_LAT if (`mode`=1 and `cmd`∈{9,10}), otherwise ALU_LAT.
- ISSUE: ALU ports are driven from the latched registers with `alu_ce`=1. Next state is WAIT.
- WAIT:
  - `alu_ce` stays 1 and the counter decrements each cycle.
  - When the counter reaches 1, `alu_res` and the flags are captured into `rsp_res`/`rsp_flags` at that edge, and the state moves to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_res`, `rsp_flags` and `rsp_id` are held stable, and `alu_ce`=0.
  - On `rsp_valid`&`rsp_ready`, the state returns to IDLE. No new grant is made in that same cycle.
- ALU operand outputs hold the last latched values in every state; `alu_ce`=0 outside ISSUE/WAIT.
- Commands, `cin` and `inp_valid` pass through unchecked. ALU errors (illegal `cmd`, `inp_valid`=0) come back only via `rsp_flags.err`.
- A requester dropping `req_valid` before being granted loses nothing and causes no side effect. Payload must be stable while `req_valid` is high.
- Only one operation is in flight; all other `req_ready` bits are 0 outside IDLE.

## Timing
- Reset values:
  - State IDLE, arbitration pointer 0.
  - `req_ready`, `rsp_valid`, `rsp_id`, `rsp_res`, `rsp_flags` are 0.
  - All `alu_*` outputs are 0.
- Reset mid-operation abandons the operation. No response is produced, and the ALU's own reset is not driven by this block.
- Handshake at cycle 0 (IDLE) gives ISSUE at cycle 1, result sampled at cycle 1+LAT, and `rsp_valid` high from cycle 2+LAT.
  - For ALU_LAT=1, `rsp_valid` rises in the third cycle after accept.
- Best-case throughput is one op per LAT+3 cycles with `rsp_ready` tied high.
- A stalled `rsp_ready` holds RESP indefinitely, and no request is accepted meanwhile.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at the pointer; after a grant, the pointer is set to (g+1) mod NUM_REQ.
  - Every continuously-valid requester is served within NUM_REQ grants.
- `ALU_ARB_RR_EN` undefined: fixed priority, where the lowest index wins. There is no pointer register.

## Structure
- `alu_arb_pkg` contains:
  - the state enum `arb_state_e`;
  - the packed struct `alu_flags_t`, ordered {err, oflow, cout, g, l, e};
  - the multiply command constants `CMD_MUL_INC`=9 and `CMD_MUL_SHL`=10.
- Sub-module `alu_rr_arbiter` (NUM_REQ): combinational one-hot grant from the request vector and pointer, plus the pointer register. It honours `ALU_ARB_RR_EN`.

## Test plan
- Reset release with no requests: all outputs 0, state IDLE.
- Single requester, opa=8'h0F, opb=8'h01, mode=1, cmd=ADD:
  - `req_ready[0]` high in cycle 0, `alu_ce` high in cycles 1–2;
  - `rsp_valid` from cycle 3 with `rsp_res`=16'h0010, `rsp_id`=0.
- Multiply with mode=1, cmd=9, opa=3, opb=4: WAIT lasts MUL_LAT cycles; `rsp_res`=16'd20, i.e. (3+1)*(4+1).
- All 4 requesters held valid with `ALU_ARB_RR_EN` defined: grant order 0,1,2,3,0. Without the macro: grant order 0,0,0.
- `rsp_ready` held low for 5 cycles in RESP: response stays stable, no `req_ready` is asserted; completion follows on release.
- `rst` asserted during WAIT: next cycle is IDLE with all outputs 0 and no response; a new request completes normally afterwards.
